// File: rtl/apx_pkg.sv
// Shared types and helpers for the approximate-multiplier scheduler.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package apx_pkg;

    // Ceiling log2, with a minimum of 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Default cluster geometry; these values also size the stage records below.
    localparam int P_BWOP    = 10;
    localparam int P_NREQ    = 4;
    localparam int P_MAX_NAB = 4;
    localparam int P_PIPE    = 2;
    localparam int P_IDW     = clog2(P_NREQ);
    localparam int P_NABW    = clog2(P_MAX_NAB + 1);

    // Operand stage: masked operands waiting for the multiplier.
    typedef struct packed {
        logic              vld;
        logic [P_IDW-1:0]  id;
        logic [P_BWOP-1:0] a_m;
        logic [P_BWOP-1:0] b_m;
    } op_stage_t;

    // Result stage: truncated product travelling to the output register.
    typedef struct packed {
        logic              vld;
        logic [P_IDW-1:0]  id;
        logic [P_BWOP-1:0] prod;
    } res_stage_t;

    // Operand mask for a truncation level; levels above P_MAX_NAB clamp.
    function automatic logic [P_BWOP-1:0] nab_mask(input logic [P_NABW-1:0] nab);
        logic [P_BWOP-1:0] m;
        m = '1;
        if (int'(nab) > P_MAX_NAB) m = m << P_MAX_NAB;
        else                       m = m << nab;
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from pointer+1, wrapping, and grants the first request.
// Latency: grant is combinational from req; pointer updates on the accepting edge.
// Backpressure: en=0 forces gnt to zero and freezes the pointer.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] idx;
    logic           found;

    // First asserted request after the pointer wins; nothing is granted while disabled.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
        if (!en) gnt = '0;
    end

    // Pointer follows the winner only when a grant is actually taken.
    always_ff @(posedge clk) begin
        if (rst)               ptr <= IDW'(NREQ - 1);
        else if (en && found)  ptr <= gnt_idx;
    end

endmodule

// File: rtl/apx_mul_sched.sv
// Round-robin sharing of one truncated approximate multiplier among NREQ requesters.
// Latency: PIPE cycles from accept to out_valid; one result per cycle when out_ready=1.
// Backpressure: out_valid & ~out_ready freezes every stage and drops all req_ready.
module apx_mul_sched
    import apx_pkg::*;
#(
    parameter int BWOP    = P_BWOP,
    parameter int NREQ    = P_NREQ,
    parameter int MAX_NAB = P_MAX_NAB,
    parameter int PIPE    = P_PIPE,
    localparam int IDW    = clog2(NREQ),
    localparam int NABW   = clog2(MAX_NAB + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BWOP-1:0] req_a,
    input  logic [NREQ*BWOP-1:0] req_b,
    input  logic [NREQ*NABW-1:0] req_nab,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BWOP-1:0]      out_c,
    output logic [IDW-1:0]       out_id
);

    // With PIPE=1 the output register is the only stage; otherwise one operand
    // stage feeds PIPE-1 result stages, the last being the output register.
    localparam int RSTG = (PIPE > 1) ? PIPE - 1 : 1;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  sel;
    logic            stall;
    logic            accept;
    logic [BWOP-1:0] a_sel, b_sel, mask, a_m, b_m;
    logic [NABW-1:0] nab_sel;
    res_stage_t      res_q [RSTG];

    assign out_valid = res_q[RSTG-1].vld;
    assign out_c     = res_q[RSTG-1].prod;
    assign out_id    = res_q[RSTG-1].id;
    assign stall     = out_valid & ~out_ready;
    assign req_ready = gnt;
    assign accept    = |gnt;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .en      (~stall),
        .gnt     (gnt),
        .gnt_idx (sel)
    );

    // Select the winner's operands and apply its clamped truncation mask.
    always_comb begin
        a_sel   = req_a[sel*BWOP +: BWOP];
        b_sel   = req_b[sel*BWOP +: BWOP];
        nab_sel = req_nab[sel*NABW +: NABW];
        mask    = nab_mask(nab_sel);
        a_m     = a_sel & mask;
        b_m     = b_sel & mask;
    end

    if (PIPE == 1) begin : g_pipe1
        // Single stage: multiply straight into the output register.
        always_ff @(posedge clk) begin
            if (rst)         res_q[0] <= '0;
            else if (!stall) res_q[0] <= '{vld: accept, id: sel, prod: a_m * b_m};
        end
    end else begin : g_pipen
        op_stage_t op_q;

        // Operand stage captures the masked operands of the accepted request; bubbles advance too.
        always_ff @(posedge clk) begin
            if (rst)         op_q <= '0;
            else if (!stall) op_q <= '{vld: accept, id: sel, a_m: a_m, b_m: b_m};
        end

        // Multiply into the first result stage, then shift toward the output register.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < RSTG; k++) res_q[k] <= '0;
            end else if (!stall) begin
                res_q[0] <= '{vld: op_q.vld, id: op_q.id, prod: op_q.a_m * op_q.b_m};
                for (int k = 1; k < RSTG; k++) res_q[k] <= res_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_apx_mul_sched.sv
// Directed and scoreboarded checks of the shared approximate-multiplier scheduler.
// Latency: expects results PIPE=2 cycles after accept.
// Backpressure: exercises out_ready stalls and verifies frozen outputs and zero req_ready.
module tb_apx_mul_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [39:0] req_a;
    logic [39:0] req_b;
    logic [11:0] req_nab;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_c;
    logic [1:0]  out_id;

    int n_pass  = 0;
    int n_total = 0;

    int exp_c [4];
    int q_c  [$];
    int q_id [$];
    int wait_cnt [4];
    logic [3:0] acc_prev;
    logic       gen_on;

    always #5 clk = ~clk;

    apx_mul_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_nab   (req_nab),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_id    (out_id)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b, input int nab);
        req_a[i*10 +: 10] = 10'(a);
        req_b[i*10 +: 10] = 10'(b);
        req_nab[i*3 +: 3] = 3'(nab);
    endtask

    // Reference: clear the low n bits by shifting, multiply, keep 10 bits.
    function automatic int model(input int a, input int b, input int nab);
        int n, ma, mb;
        n  = (nab > 4) ? 4 : nab;
        ma = (a >> n) << n;
        mb = (b >> n) << n;
        return (ma * mb) % 1024;
    endfunction

    // One isolated request: grant now, nothing next cycle, result the cycle after.
    task automatic do_single(input string tag, input int i, input int a, input int b,
                             input int nab, input int c);
        set_req(i, a, b, nab);
        req_valid = 4'(1 << i);
        #4;
        chk({tag, "_rdy"}, int'(req_ready), 1 << i);
        tick();
        req_valid = 4'b0000;
        #4;
        chk({tag, "_lat1_vld"}, int'(out_valid), 0);
        tick();
        #4;
        chk({tag, "_vld"}, int'(out_valid), 1);
        chk({tag, "_c"}, int'(out_c), c);
        chk({tag, "_id"}, int'(out_id), i);
        tick();
        #4;
        chk({tag, "_after_vld"}, int'(out_valid), 0);
        tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One cycle of the random phase: drive, sample mid-cycle, score, advance.
    task automatic rand_cycle();
        int g;
        for (int i = 0; i < 4; i++) begin
            if (acc_prev[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && gen_on && ($urandom_range(1, 0) == 1)) begin
                set_req(i, int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)),
                        int'($urandom_range(7, 0)));
                req_valid[i] = 1'b1;
            end
        end
        out_ready = gen_on ? ($urandom_range(3, 0) != 0) : 1'b1;
        #4;
        if (out_valid && out_ready) begin
            chk("sb_nonempty", int'(q_c.size() > 0), 1);
            if (q_c.size() > 0) begin
                chk("sb_c", int'(out_c), q_c.pop_front());
                chk("sb_id", int'(out_id), q_id.pop_front());
            end
        end
        chk("rdy_subset", int'(req_ready & ~req_valid), 0);
        acc_prev = req_ready;
        if (req_ready != 4'b0000) begin
            g = 0;
            for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
            q_c.push_back(model(int'(req_a[g*10 +: 10]), int'(req_b[g*10 +: 10]),
                                int'(req_nab[g*3 +: 3])));
            q_id.push_back(g);
            chk("starve", int'(wait_cnt[g] <= 3), 1);
            wait_cnt[g] = 0;
            for (int i = 0; i < 4; i++)
                if (i != g && req_valid[i]) wait_cnt[i] = wait_cnt[i] + 1;
        end
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_a     = '0;
        req_b     = '0;
        req_nab   = '0;
        out_ready = 1'b1;
        exp_c[0]  = 'h023;
        exp_c[1]  = 'h110;
        exp_c[2]  = 'h100;
        exp_c[3]  = 'h0C0;
        tick();
        tick();
        #4;
        chk("rst_vld", int'(out_valid), 0);
        chk("rst_c", int'(out_c), 0);
        chk("rst_id", int'(out_id), 0);
        chk("rst_rdy", int'(req_ready), 0);
        tick();
        rst = 1'b0;

        // Exact product, then one bit of truncation, then a clamped level.
        do_single("t1_nab0", 0, 'h3FF, 'h003, 0, 'h3FD);
        do_single("t1_nab1", 0, 'h3FF, 'h003, 1, 'h3FC);
        do_single("t2_clamp", 2, 'h3FF, 'h3FF, 7, 'h100);

        // All requesters held: rotation 0,1,2,3,... and one result per cycle.
        pulse_reset();
        set_req(0, 'h005, 'h007, 0);
        set_req(1, 'h011, 'h010, 0);
        set_req(2, 'h3FF, 'h3FF, 7);
        set_req(3, 'h01C, 'h00C, 3);
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) req_valid = 4'b0000;
            #4;
            chk("t3_rdy", int'(req_ready), (k < 8) ? (1 << (k % 4)) : 0);
            if (k >= 2) begin
                chk("t3_vld", int'(out_valid), 1);
                chk("t3_id", int'(out_id), (k - 2) % 4);
                chk("t3_c", int'(out_c), exp_c[(k - 2) % 4]);
            end else begin
                chk("t3_vld0", int'(out_valid), 0);
            end
            tick();
        end
        #4;
        chk("t3_drained", int'(out_valid), 0);
        tick();

        // Stall for 5 cycles while all requesters wait.
        pulse_reset();
        req_valid = 4'b1111;
        #4;
        chk("t4_rdy0", int'(req_ready), 'b0001);
        tick();
        #4;
        chk("t4_rdy1", int'(req_ready), 'b0010);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #4;
            chk("t4_stall_rdy", int'(req_ready), 0);
            chk("t4_stall_vld", int'(out_valid), 1);
            chk("t4_stall_id", int'(out_id), 0);
            chk("t4_stall_c", int'(out_c), 'h023);
            tick();
        end
        out_ready = 1'b1;
        #4;
        chk("t4_rel_rdy", int'(req_ready), 'b0100);
        chk("t4_rel_id", int'(out_id), 0);
        tick();
        req_valid = 4'b0000;
        #4;
        chk("t4_o1_vld", int'(out_valid), 1);
        chk("t4_o1_id", int'(out_id), 1);
        chk("t4_o1_c", int'(out_c), 'h110);
        tick();
        #4;
        chk("t4_o2_vld", int'(out_valid), 1);
        chk("t4_o2_id", int'(out_id), 2);
        chk("t4_o2_c", int'(out_c), 'h100);
        tick();
        #4;
        chk("t4_o3_vld", int'(out_valid), 0);
        tick();

        // Reset with two results in flight; pointer must restart so req 1 beats req 3.
        req_valid = 4'b0011;
        #4;
        chk("t5_g0", int'(req_ready), 'b0001);
        tick();
        #4;
        chk("t5_g1", int'(req_ready), 'b0010);
        tick();
        req_valid = 4'b0000;
        #4;
        chk("t5_inflight", int'(out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #4;
        chk("t5_post_rst0", int'(out_valid), 0);
        tick();
        #4;
        chk("t5_post_rst1", int'(out_valid), 0);
        req_valid = 4'b1010;
        #4;
        chk("t5_ptr_rdy", int'(req_ready), 'b0010);
        tick();
        req_valid = 4'b0000;
        #4;
        chk("t5_lat1", int'(out_valid), 0);
        tick();
        #4;
        chk("t5_vld", int'(out_valid), 1);
        chk("t5_id", int'(out_id), 1);
        chk("t5_c", int'(out_c), 'h110);
        tick();

        // Random traffic against the masked-product scoreboard, then drain.
        pulse_reset();
        acc_prev = 4'b0000;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        gen_on = 1'b1;
        for (int k = 0; k < 600; k++) rand_cycle();
        gen_on = 1'b0;
        for (int k = 0; k < 20; k++) rand_cycle();
        chk("sb_drained", q_c.size(), 0);
        chk("sb_idle_vld", int'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
